// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: divider-paced x/y counters with sync, display-enable and start strobes.
// All outputs are registered from the next counter values (zero skew to xpos/ypos); en=0 freezes everything and silences strobes.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int PIX_DIV  = 2,
   parameter int CW       = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   output logic          HSync,
   output logic          VSync,
   output logic [CW-1:0] xpos,
   output logic [CW-1:0] ypos,
   output logic          active,
   output logic          pix_ce,
   output logic          line_start,
   output logic          frame_start
);

   localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
   localparam int DW        = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   if (PIX_DIV < 1) begin : g_bad_div
      $fatal(1, "vga_timing_gen: PIX_DIV must be >= 1");
   end
   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
      $fatal(1, "vga_timing_gen: every timing parameter must be >= 1");
   end
   if (CW < 1 || (CW < 31 && (MAX_TOTAL - 1) >= (1 << CW))) begin : g_bad_cw
      $fatal(1, "vga_timing_gen: CW too narrow for the raster size");
   end

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_STOP  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_STOP  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
   logic          hsync_q, hsync_d, vsync_q, vsync_d;
   logic          active_q, active_d;
   logic          pix_ce_q, pix_ce_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;
   logic          tick, adv;

   always_comb begin
      tick   = (div_q == DIV_LAST);
      adv    = en & tick;
      div_d  = div_q;
      xpos_d = xpos_q;
      ypos_d = ypos_q;

      if (en) begin
         div_d = tick ? '0 : div_q + DW'(1);
      end

      if (adv) begin
         if (xpos_q == H_LAST) begin
            xpos_d = '0;
            ypos_d = (ypos_q == V_LAST) ? '0 : ypos_q + CW'(1);
         end else begin
            xpos_d = xpos_q + CW'(1);
         end
      end

      // Decode from the next position so sync/active line up with the coordinates.
      hsync_d       = ((xpos_d >= HS_START) && (xpos_d <= HS_STOP)) ? HS_POL : ~HS_POL;
      vsync_d       = ((ypos_d >= VS_START) && (ypos_d <= VS_STOP)) ? VS_POL : ~VS_POL;
      active_d      = (xpos_d < H_ACT) && (ypos_d < V_ACT);
      pix_ce_d      = adv;
      line_start_d  = adv && (xpos_d == '0);
      frame_start_d = line_start_d && (ypos_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q         <= '0;
         xpos_q        <= H_LAST;
         ypos_q        <= V_LAST;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         active_q      <= 1'b0;
         pix_ce_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         xpos_q        <= xpos_d;
         ypos_q        <= ypos_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         active_q      <= active_d;
         pix_ce_q      <= pix_ce_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign xpos        = xpos_q;
   assign ypos        = ypos_q;
   assign HSync       = hsync_q;
   assign VSync       = vsync_q;
   assign active      = active_q;
   assign pix_ce      = pix_ce_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default 640x480 instance driven from a directed vector table; small variant checked every cycle against a raster scoreboard.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #20 clk = ~clk;

   logic       rst0_n, en0, rst1_n, en1;
   logic       hs0, vs0, act0, pce0, ls0, fs0;
   logic [9:0] x0, y0;
   logic       hs1, vs1, act1, pce1, ls1, fs1;
   logic [3:0] x1, y1;

   int checks = 0;
   int errors = 0;

   vga_timing_gen dut0 (
      .clk(clk), .rst_n(rst0_n), .en(en0),
      .HSync(hs0), .VSync(vs0), .xpos(x0), .ypos(y0),
      .active(act0), .pix_ce(pce0), .line_start(ls0), .frame_start(fs0)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b0), .PIX_DIV(1), .CW(4)
   ) dut1 (
      .clk(clk), .rst_n(rst1_n), .en(en1),
      .HSync(hs1), .VSync(vs1), .xpos(x1), .ypos(y1),
      .active(act1), .pix_ce(pce1), .line_start(ls1), .frame_start(fs1)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard for the small variant (15 x 8 raster, 120 positions)
   typedef struct {
      int x; int y; int hs; int vs; int act; int pce; int ls; int fs;
   } exp_t;

   exp_t sb_q[$];
   int   m_pos;
   bit   sb_on = 1'b0;

   function automatic exp_t mk(input int pos, input int pce, input int ls, input int fs);
      exp_t e;
      e.x   = pos % 15;
      e.y   = pos / 15;
      e.hs  = (e.x >= 10 && e.x <= 12) ? 1 : 0;
      e.vs  = (e.y >= 5 && e.y <= 6) ? 0 : 1;
      e.act = (e.x < 8 && e.y < 4) ? 1 : 0;
      e.pce = pce;
      e.ls  = ls;
      e.fs  = fs;
      return e;
   endfunction

   always @(posedge clk) begin
      if (sb_on) begin
         if (!rst1_n) begin
            m_pos = 119;
            sb_q.push_back(mk(m_pos, 0, 0, 0));
         end else if (en1) begin
            m_pos = (m_pos + 1) % 120;
            sb_q.push_back(mk(m_pos, 1, (m_pos % 15 == 0) ? 1 : 0, (m_pos == 0) ? 1 : 0));
         end else begin
            sb_q.push_back(mk(m_pos, 0, 0, 0));
         end
      end
   end

   // An asynchronous reset overrides whatever the last edge produced.
   always @(negedge rst1_n) begin
      if (sb_on) begin
         sb_q.delete();
         m_pos = 119;
         sb_q.push_back(mk(m_pos, 0, 0, 0));
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (sb_on && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         checks++;
         if (int'(x1) != e.x || int'(y1) != e.y || int'(hs1) != e.hs || int'(vs1) != e.vs ||
             int'(act1) != e.act || int'(pce1) != e.pce || int'(ls1) != e.ls || int'(fs1) != e.fs) begin
            errors++;
            $display("FAIL sb t=%0t got x=%0d y=%0d hs=%0d vs=%0d act=%0d ce=%0d ls=%0d fs=%0d required x=%0d y=%0d hs=%0d vs=%0d act=%0d ce=%0d ls=%0d fs=%0d",
                     $time, x1, y1, hs1, vs1, act1, pce1, ls1, fs1,
                     e.x, e.y, e.hs, e.vs, e.act, e.pce, e.ls, e.fs);
         end
      end
   end

   // ---------------- directed vectors for the default instance
   typedef struct {
      int en; int n; int x; int y; int hs; int vs; int act; int pce; int ls; int fs;
   } vec_t;

   localparam int NV = 23;
   vec_t vt[NV];

   initial begin
      #(40 * 30000);
      $display("FAIL watchdog: got no finish, required finish before %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int found, n, nls, npce;

      //           en  n     x    y    hs vs act ce ls fs
      vt[0]  = '{1, 1,    799, 524, 1, 1, 0, 0, 0, 0};
      vt[1]  = '{1, 1,    0,   0,   1, 1, 1, 1, 1, 1};
      vt[2]  = '{1, 1,    0,   0,   1, 1, 1, 0, 0, 0};
      vt[3]  = '{1, 1,    1,   0,   1, 1, 1, 1, 0, 0};
      vt[4]  = '{1, 198,  100, 0,   1, 1, 1, 1, 0, 0};
      vt[5]  = '{0, 1,    100, 0,   1, 1, 1, 0, 0, 0};
      vt[6]  = '{0, 99,   100, 0,   1, 1, 1, 0, 0, 0};
      vt[7]  = '{1, 1,    100, 0,   1, 1, 1, 0, 0, 0};
      vt[8]  = '{1, 1,    101, 0,   1, 1, 1, 1, 0, 0};
      vt[9]  = '{1, 1,    101, 0,   1, 1, 1, 0, 0, 0};
      vt[10] = '{0, 10,   101, 0,   1, 1, 1, 0, 0, 0};
      vt[11] = '{1, 1,    102, 0,   1, 1, 1, 1, 0, 0};
      vt[12] = '{1, 1074, 639, 0,   1, 1, 1, 1, 0, 0};
      vt[13] = '{1, 2,    640, 0,   1, 1, 0, 1, 0, 0};
      vt[14] = '{1, 30,   655, 0,   1, 1, 0, 1, 0, 0};
      vt[15] = '{1, 1,    655, 0,   1, 1, 0, 0, 0, 0};
      vt[16] = '{1, 1,    656, 0,   0, 1, 0, 1, 0, 0};
      vt[17] = '{1, 190,  751, 0,   0, 1, 0, 1, 0, 0};
      vt[18] = '{1, 2,    752, 0,   1, 1, 0, 1, 0, 0};
      vt[19] = '{1, 94,   799, 0,   1, 1, 0, 1, 0, 0};
      vt[20] = '{1, 2,    0,   1,   1, 1, 1, 1, 1, 0};
      vt[21] = '{1, 1600, 0,   2,   1, 1, 1, 1, 1, 0};
      vt[22] = '{1, 1312, 656, 2,   0, 1, 0, 1, 0, 0};

      rst0_n = 1'b0; en0 = 1'b0;
      rst1_n = 1'b0; en1 = 1'b0;
      #10;
      m_pos = 119;
      sb_q.delete();
      sb_on = 1'b1;

      @(posedge clk); #5;
      chk("rst xpos", int'(x0), 799);
      chk("rst ypos", int'(y0), 524);
      chk("rst HSync", int'(hs0), 1);
      chk("rst VSync", int'(vs0), 1);
      chk("rst active", int'(act0), 0);
      chk("rst pix_ce", int'(pce0), 0);
      chk("rst line_start", int'(ls0), 0);
      chk("rst frame_start", int'(fs0), 0);

      repeat (2) @(posedge clk);
      #5;
      rst0_n = 1'b1;
      en0    = 1'b1;

      for (int i = 0; i < NV; i++) begin
         en0 = vt[i].en[0];
         for (int k = 0; k < vt[i].n; k++) begin
            @(posedge clk); #5;
            if (vt[i].en == 0)
               chk($sformatf("row%0d paused strobes", i), int'({pce0, ls0, fs0}), 0);
         end
         chk($sformatf("row%0d xpos", i), int'(x0), vt[i].x);
         chk($sformatf("row%0d ypos", i), int'(y0), vt[i].y);
         chk($sformatf("row%0d HSync", i), int'(hs0), vt[i].hs);
         chk($sformatf("row%0d VSync", i), int'(vs0), vt[i].vs);
         chk($sformatf("row%0d active", i), int'(act0), vt[i].act);
         chk($sformatf("row%0d pix_ce", i), int'(pce0), vt[i].pce);
         chk($sformatf("row%0d line_start", i), int'(ls0), vt[i].ls);
         chk($sformatf("row%0d frame_start", i), int'(fs0), vt[i].fs);
      end

      // Small variant: first tick on the first edge after release.
      rst1_n = 1'b1;
      en1    = 1'b1;
      @(posedge clk); #5;
      chk("v first xpos", int'(x1), 0);
      chk("v first ypos", int'(y1), 0);
      chk("v first frame_start", int'(fs1), 1);

      for (int k = 0; k < 200; k++) begin
         en1 = ($urandom_range(0, 3) != 0);
         @(posedge clk); #5;
      end
      en1 = 1'b1;

      found = 0;
      for (int k = 0; k < 300 && found == 0; k++) begin
         @(posedge clk); #5;
         if (fs1) found = 1;
      end
      chk("v wait frame_start", found, 1);

      n = 0; nls = 0; npce = 0; found = 0;
      for (int k = 0; k < 300 && found == 0; k++) begin
         @(posedge clk); #5;
         n++;
         nls  += int'(ls1);
         npce += int'(pce1);
         if (fs1) found = 1;
      end
      chk("v frame period clks", n, 120);
      chk("v line_start per frame", nls, 8);
      chk("v pix_ce per frame", npce, 120);

      found = 0;
      for (int k = 0; k < 200 && found == 0; k++) begin
         @(posedge clk); #5;
         if (y1 == 4'd3) found = 1;
      end
      chk("v wait ypos 3", found, 1);

      #1 rst1_n = 1'b0;
      #1;
      chk("v async rst xpos", int'(x1), 14);
      chk("v async rst ypos", int'(y1), 7);
      chk("v async rst HSync", int'(hs1), 0);
      chk("v async rst VSync", int'(vs1), 1);
      chk("v async rst active", int'(act1), 0);
      chk("v async rst strobes", int'({pce1, ls1, fs1}), 0);

      repeat (3) @(posedge clk);
      #5;
      rst1_n = 1'b1;
      @(posedge clk); #5;
      chk("v restart xpos", int'(x1), 0);
      chk("v restart ypos", int'(y1), 0);
      chk("v restart frame_start", int'(fs1), 1);

      repeat (130) @(posedge clk);
      #5;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
